video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Generates raster timing (DE, HSYNC, VSYNC), pixel coordinates and an 8-bit-per-channel test pattern in the pixclk domain. Sits directly upstream of the three per-channel TMDS encoders.
- DE feeds each encoder's data-enable input.
- {vsync, hsync} feeds the blue-channel control input; red and green channels receive 2'b00.
- All outputs are registered and mutually aligned, so the encoder sees a coherent pixel/control word every cycle.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level
CNT_W, 12, counter / coordinate width

Ports:
pixclk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
i_en  input  1  run enable
i_pattern  input  2  0 = colour bars, 1 = solid white, 2 = 8x8 grid, 3 = horizontal ramp
o_de  output  1  active-video flag
o_hsync  output  1  horizontal sync, polarity per H_POL
o_vsync  output  1  vertical sync, polarity per V_POL
o_ctrl  output  2  {o_vsync, o_hsync} for the blue-channel encoder
o_x  output  CNT_W  pixel column, valid when o_de = 1
o_y  output  CNT_W  pixel row, valid when o_de = 1
o_frame_start  output  1  one-cycle pulse at pixel (0,0)
o_line_start  output  1  one-cycle pulse at column 0 of every line, including blanking lines
o_red, o_green, o_blue  output  8 each  pattern pixel data; 0 when o_de = 0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt wraps; it runs 0..V_TOTAL-1 and wraps at the end of the last line.
  - Both counters advance only when i_en = 1.
- Region decode, from the current counter values:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_on = (H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC)
  - vs_on = (V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC), whole lines
  - Each sync output = POL when on, ~POL otherwise.
- Latency: every output is registered once from the decode of the counters. Outputs at cycle n+1 describe counter state at cycle n. o_de, syncs, o_x/o_y, pulses and RGB are all co-aligned; no extra stages.
- Reset (asynchronous) and i_en = 0 give the same output state:
  - counters = 0
  - o_de = 0, o_hsync = ~H_POL, o_vsync = ~V_POL, o_ctrl matches the sync outputs
  - o_x = 0, o_y = 0, pulses = 0, RGB = 0
- Restart: after i_en rises, the first cycle's registered outputs show pixel (0,0) with o_frame_start = 1.
- Reset mid-frame: restarts the raster at (0,0). No partial-frame resume.
- Pulses:
  - o_line_start = 1 when h_cnt = 0.
  - o_frame_start = 1 when h_cnt = 0 and v_cnt = 0.
- Colour bars:
  - BAR_W = H_ACTIVE/8 (integer division, localparam).
  - A bar sub-counter and a 3-bit bar index clear at h_cnt = 0. The index increments each time the sub-counter reaches BAR_W-1 and saturates at 7, so any remainder columns extend bar 7. No divider in the datapath.
  - Order, with each channel 8'hFF or 8'h00: white, yellow, cyan, green, magenta, red, blue, black.
- Grid: white where x[2:0] = 0 or y[2:0] = 0, else black.
- Ramp: R = G = B = x[7:0], wrapping every 256 columns.
- i_pattern is sampled every cycle. A mid-frame change takes effect on the next pixel, with no glitch on the timing outputs.

Decomposition:
- Shared package holds:
  - the 640x480@60 timing constants set, plus a 1280x720 set for later use
  - the pattern-select encoding (PAT_BARS = 0, PAT_WHITE = 1, PAT_GRID = 2, PAT_RAMP = 3)
  - the 8-entry bar colour table
- One natural sub-module: vtg_pattern. It is combinational plus the bar sub-counter, maps (x, y, h_cnt = 0, pattern) to RGB, and its output is registered in the parent.

Test Plan:
- Release reset with i_en = 1 → o_de rises on the first clock; o_x counts 0..639 with o_de = 1 for exactly 640 cycles; o_de = 0 for 160 cycles; o_line_start pulses every 800 cycles.
- Line timing → o_hsync = 0 for exactly 96 cycles, starting at the cycle where o_de has been low for 16 cycles; o_ctrl[0] equals o_hsync throughout.
- Full frame → o_frame_start period = 420000 cycles; o_vsync = 0 for 1600 cycles, starting 10 lines (8000 cycles) after the last active pixel; 480 lines carry o_de.
- Colour bars → at row 0, columns 0, 80, 400 and 639 give RGB = FFFFFF, FFFF00, FF0000 and 000000 respectively; RGB = 0 whenever o_de = 0.
- Drop i_en at x = 300, y = 100 for 5 cycles, then raise it → outputs hold the reset state while low; the first cycle after raising shows (0,0) with o_frame_start = 1. Repeat with reset asserted mid-line for the same result.
- i_pattern = 2 → white at (0,5), (8,3) and (13,16), black at (13,5); i_pattern = 3 → x = 300 gives RGB = 2C2C2C.

Source files
------------

// File: rtl/vtg_pkg.sv
// Shared raster timing sets, pattern-select encoding and bar colour table
// for the video timing generator.
package vtg_pkg;

    // 640x480 @ 60 Hz
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // 1280x720 @ 60 Hz
    localparam int HD_H_ACTIVE  = 1280;
    localparam int HD_H_FP      = 110;
    localparam int HD_H_SYNC    = 40;
    localparam int HD_H_BP      = 220;
    localparam int HD_V_ACTIVE  = 720;
    localparam int HD_V_FP      = 5;
    localparam int HD_V_SYNC    = 5;
    localparam int HD_V_BP      = 20;

    localparam int VTG_CNT_W    = 12;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_WHITE = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_RAMP  = 2'd3
    } pattern_t;

    // Index 0 (leftmost bar) is the least significant entry: white, yellow,
    // cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_COLORS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/vtg_pattern.sv
// Test-pattern generator: maps the current raster position and pattern
// select to an RGB word. Colour-bar position is tracked by a counter.
module vtg_pattern
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int CNT_W    = VTG_CNT_W
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_line_start,
    input  logic [7:0]  i_x,
    input  logic [2:0]  i_y,
    input  logic [1:0]  i_pattern,
    output logic [23:0] o_rgb
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [CNT_W-1:0] bar_sub_reg;
    logic [CNT_W-1:0] bar_sub;
    logic [2:0]       bar_idx_reg;
    logic [2:0]       bar_idx;

    // Column 0 forces a fresh bar so the registered state never lags a line.
    always_comb begin
        bar_sub = i_line_start ? '0 : bar_sub_reg;
        bar_idx = i_line_start ? 3'd0 : bar_idx_reg;
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= 3'd0;
        end else if (!i_en) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= 3'd0;
        end else if (bar_sub == BAR_LAST) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= (bar_idx == 3'd7) ? bar_idx : bar_idx + 3'd1;
        end else begin
            bar_sub_reg <= bar_sub + 1'b1;
            bar_idx_reg <= bar_idx;
        end
    end

    always_comb begin
        o_rgb = 24'h000000;
        case (pattern_t'(i_pattern))
            PAT_BARS:  o_rgb = BAR_COLORS[bar_idx];
            PAT_WHITE: o_rgb = 24'hFFFFFF;
            PAT_GRID:  o_rgb = (i_x[2:0] == 3'd0 || i_y == 3'd0) ? 24'hFFFFFF : 24'h000000;
            PAT_RAMP:  o_rgb = {3{i_x}};
            default:   o_rgb = 24'h000000;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: DE/HSYNC/VSYNC, pixel coordinates, line/frame
// pulses and test-pattern RGB, all registered once from the counter decode.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CNT_W    = VTG_CNT_W
) (
    input  logic             pixclk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [1:0]       i_pattern,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [1:0]       o_ctrl,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_frame_start,
    output logic             o_line_start,
    output logic [7:0]       o_red,
    output logic [7:0]       o_green,
    output logic [7:0]       o_blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;
    logic             de_reg;
    logic             hsync_reg;
    logic             vsync_reg;
    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] y_reg;
    logic             frame_start_reg;
    logic             line_start_reg;
    logic [23:0]      rgb_reg;

    logic        active;
    logic        hs_on;
    logic        vs_on;
    logic        line_start;
    logic        frame_start;
    logic [23:0] pat_rgb;

    always_comb begin
        active      = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
        hs_on       = (h_cnt_reg >= H_HS_BEG) && (h_cnt_reg < H_HS_END);
        vs_on       = (v_cnt_reg >= V_VS_BEG) && (v_cnt_reg < V_VS_END);
        line_start  = (h_cnt_reg == '0);
        frame_start = line_start && (v_cnt_reg == '0);
    end

    vtg_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .CNT_W    (CNT_W)
    ) u_pattern (
        .pixclk       (pixclk),
        .reset        (reset),
        .i_en         (i_en),
        .i_line_start (line_start),
        .i_x          (h_cnt_reg[7:0]),
        .i_y          (v_cnt_reg[2:0]),
        .i_pattern    (i_pattern),
        .o_rgb        (pat_rgb)
    );

    // Disable behaves exactly like reset so a re-enable always starts at (0,0).
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            de_reg          <= 1'b0;
            hsync_reg       <= ~H_POL;
            vsync_reg       <= ~V_POL;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            rgb_reg         <= 24'h000000;
        end else if (!i_en) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            de_reg          <= 1'b0;
            hsync_reg       <= ~H_POL;
            vsync_reg       <= ~V_POL;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            rgb_reg         <= 24'h000000;
        end else begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 1'b1;
            end
            de_reg          <= active;
            hsync_reg       <= hs_on ? H_POL : ~H_POL;
            vsync_reg       <= vs_on ? V_POL : ~V_POL;
            x_reg           <= h_cnt_reg;
            y_reg           <= v_cnt_reg;
            frame_start_reg <= frame_start;
            line_start_reg  <= line_start;
            rgb_reg         <= active ? pat_rgb : 24'h000000;
        end
    end

    assign o_de          = de_reg;
    assign o_hsync       = hsync_reg;
    assign o_vsync       = vsync_reg;
    assign o_ctrl        = {vsync_reg, hsync_reg};
    assign o_x           = x_reg;
    assign o_y           = y_reg;
    assign o_frame_start = frame_start_reg;
    assign o_line_start  = line_start_reg;
    assign o_red         = rgb_reg[23:16];
    assign o_green       = rgb_reg[15:8];
    assign o_blue        = rgb_reg[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen, using a reduced raster so whole
// frames fit in a short run; expectations come from a positional model.
module tb_video_timing_gen;

    localparam int HA = 324, HF = 8, HS = 32, HB = 16;
    localparam int VA = 20,  VF = 2, VS = 2,  VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int BW = HA / 8;

    logic        pixclk = 1'b0;
    logic        reset = 1'b1;
    logic        i_en = 1'b0;
    logic [1:0]  i_pattern = 2'd0;
    logic        o_de, o_hsync, o_vsync, o_frame_start, o_line_start;
    logic [1:0]  o_ctrl;
    logic [11:0] o_x, o_y;
    logic [7:0]  o_red, o_green, o_blue;

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .H_POL (1'b0), .V_POL (1'b0), .CNT_W (12)
    ) dut (
        .pixclk        (pixclk),
        .reset         (reset),
        .i_en          (i_en),
        .i_pattern     (i_pattern),
        .o_de          (o_de),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_ctrl        (o_ctrl),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_frame_start (o_frame_start),
        .o_line_start  (o_line_start),
        .o_red         (o_red),
        .o_green       (o_green),
        .o_blue        (o_blue)
    );

    always #5 pixclk = ~pixclk;

    typedef struct packed {
        logic        de, hs, vs, fs, ls;
        logic [11:0] x, y;
        logic [23:0] rgb;
    } out_t;

    out_t obs, expv, rst_o;
    assign obs = {o_de, o_hsync, o_vsync, o_frame_start, o_line_start, o_x, o_y,
                  o_red, o_green, o_blue};

    localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int vectors = 0;
    int miscompares = 0;
    int mh = 0, mv = 0;
    bit mask_xy = 0;

    // Expected outputs for raster position (h,v); coordinates only matter in active video.
    function automatic out_t model(input int h, input int v, input logic [1:0] pat, input bit run);
        out_t m;
        int bi;
        logic [7:0] r8;
        m = '0;
        m.hs = 1'b1;
        m.vs = 1'b1;
        if (!run) return m;
        m.de = (h < HA) && (v < VA);
        m.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        m.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        m.ls = (h == 0);
        m.fs = (h == 0) && (v == 0);
        if (m.de) begin
            m.x = 12'(h);
            m.y = 12'(v);
            r8 = 8'(h % 256);
            case (pat)
                2'd0: begin
                    bi = h / BW;
                    if (bi > 7) bi = 7;
                    m.rgb = BAR_TAB[bi];
                end
                2'd1: m.rgb = 24'hFFFFFF;
                2'd2: m.rgb = ((h % 8) == 0 || (v % 8) == 0) ? 24'hFFFFFF : 24'h000000;
                default: m.rgb = {r8, r8, r8};
            endcase
        end
        return m;
    endfunction

    function automatic out_t masked(input out_t o);
        out_t r;
        r = o;
        if (mask_xy) begin
            r.x = '0;
            r.y = '0;
        end
        return r;
    endfunction

    // One clock: drive on the falling edge, settle after the rising edge, advance the model.
    task automatic tick(input bit en, input bit rst, input logic [1:0] pat);
        bit run;
        @(negedge pixclk);
        i_en = en;
        reset = rst;
        i_pattern = pat;
        @(posedge pixclk);
        #1;
        run = en && !rst;
        expv = model(mh, mv, pat, run);
        mask_xy = run && !expv.de;
        if (run) begin
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end else begin
            mh = 0;
            mv = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 2'd0);
        vectors++;
        if (obs !== rst_o) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, rst_o);
        end
        vectors++;
        if (o_ctrl !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 11", o_ctrl);
        end
    endtask

    task automatic test_line();
        int de_cnt = 0, blank_cnt = 0, x_err = 0, hs_low = 0, hs_start = -1;
        int ctrl_err = 0, ls_cnt = 0;
        for (int c = 0; c < HT; c++) begin
            tick(1'b1, 1'b0, 2'd0);
            if (c == 0) begin
                vectors++;
                if (o_de !== 1'b1 || o_x !== 12'd0 || o_frame_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_pixel: got de=%b x=%0d fs=%b expected de=1 x=0 fs=1",
                             o_de, o_x, o_frame_start);
                end
            end
            if (o_de) begin
                if (o_x !== 12'(de_cnt)) x_err++;
                de_cnt++;
            end else begin
                blank_cnt++;
            end
            if (!o_hsync) begin
                if (hs_start < 0) hs_start = c;
                hs_low++;
            end
            if (o_ctrl[0] !== o_hsync) ctrl_err++;
            if (o_line_start) ls_cnt++;
        end
        vectors++;
        if (de_cnt != HA) begin miscompares++; $display("FAIL de_width: got %0d expected %0d", de_cnt, HA); end
        vectors++;
        if (blank_cnt != HT - HA) begin miscompares++; $display("FAIL h_blank: got %0d expected %0d", blank_cnt, HT - HA); end
        vectors++;
        if (x_err != 0) begin miscompares++; $display("FAIL x_sequence: got %0d bad columns expected 0", x_err); end
        vectors++;
        if (hs_low != HS) begin miscompares++; $display("FAIL hsync_width: got %0d expected %0d", hs_low, HS); end
        vectors++;
        if (hs_start != HA + HF) begin miscompares++; $display("FAIL hsync_start: got %0d expected %0d", hs_start, HA + HF); end
        vectors++;
        if (ctrl_err != 0) begin miscompares++; $display("FAIL ctrl_hsync: got %0d mismatching cycles expected 0", ctrl_err); end
        vectors++;
        if (ls_cnt != 1) begin miscompares++; $display("FAIL line_start_count: got %0d expected 1", ls_cnt); end
        tick(1'b1, 1'b0, 2'd0);
        vectors++;
        if (o_line_start !== 1'b1) begin miscompares++; $display("FAIL line_start_period: got %b expected 1", o_line_start); end
    endtask

    task automatic test_frame();
        int c = 0, f1 = -1, f2 = -1, vs_fall = -1, vs_low = 0, de_lines = 0, bad = 0;
        bit prev_de = 1'b1, prev_vs = 1'b1;
        out_t first_o, first_e;
        first_o = '0;
        first_e = '0;
        while (f2 < 0 && c < 3 * HT * VT) begin
            tick(1'b1, 1'b0, 2'd0);
            if (masked(obs) !== expv || o_ctrl !== {o_vsync, o_hsync}) begin
                if (bad == 0) begin first_o = obs; first_e = expv; end
                bad++;
            end
            if (o_frame_start) begin
                if (f1 < 0) f1 = c; else f2 = c;
            end
            if (f1 >= 0 && f2 < 0) begin
                if (!o_vsync) vs_low++;
                if (!o_vsync && prev_vs && vs_fall < 0) vs_fall = c;
                if (o_de && !prev_de) de_lines++;
            end
            prev_de = o_de;
            prev_vs = o_vsync;
            c++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL frame_model: %0d bad cycles, first got %h expected %h", bad, first_o, first_e); end
        vectors++;
        if (f1 < 0 || f2 < 0 || f2 - f1 != HT * VT) begin
            miscompares++;
            $display("FAIL frame_period: got %0d expected %0d", f2 - f1, HT * VT);
        end
        vectors++;
        if (vs_low != VS * HT) begin miscompares++; $display("FAIL vsync_width: got %0d expected %0d", vs_low, VS * HT); end
        vectors++;
        if (vs_fall - f1 != (VA + VF) * HT) begin
            miscompares++;
            $display("FAIL vsync_start: got %0d expected %0d", vs_fall - f1, (VA + VF) * HT);
        end
        vectors++;
        if (de_lines != VA) begin miscompares++; $display("FAIL active_lines: got %0d expected %0d", de_lines, VA); end
    endtask

    task automatic test_bars();
        int cols [7] = '{0, BW, 5 * BW, 7 * BW - 1, 8 * BW, HA - 1, HA};
        logic [23:0] want [7] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'h0000FF,
                                  24'h000000, 24'h000000, 24'h000000};
        logic [23:0] got [7];
        tick(1'b1, 1'b1, 2'd0);
        for (int c = 0; c <= HA; c++) begin
            tick(1'b1, 1'b0, 2'd0);
            for (int k = 0; k < 7; k++) if (cols[k] == c) got[k] = {o_red, o_green, o_blue};
        end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (got[k] !== want[k]) begin
                miscompares++;
                $display("FAIL bars_col%0d: got %h expected %h", cols[k], got[k], want[k]);
            end
        end
    endtask

    task automatic test_grid_ramp();
        int px [4] = '{0, 8, 13, 13};
        int py [4] = '{5, 3, 16, 5};
        logic [23:0] want [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
        logic [23:0] got [4] = '{24'h123456, 24'h123456, 24'h123456, 24'h123456};
        logic [23:0] ramp = 24'h123456;
        tick(1'b1, 1'b1, 2'd2);
        for (int c = 0; c < 17 * HT; c++) begin
            tick(1'b1, 1'b0, 2'd2);
            for (int k = 0; k < 4; k++)
                if (c == py[k] * HT + px[k]) got[k] = {o_red, o_green, o_blue};
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (got[k] !== want[k]) begin
                miscompares++;
                $display("FAIL grid_%0d_%0d: got %h expected %h", px[k], py[k], got[k], want[k]);
            end
        end
        tick(1'b1, 1'b1, 2'd3);
        for (int c = 0; c <= 300; c++) begin
            tick(1'b1, 1'b0, 2'd3);
            if (c == 300) ramp = {o_red, o_green, o_blue};
        end
        vectors++;
        if (ramp !== 24'h2C2C2C) begin miscompares++; $display("FAIL ramp_x300: got %h expected 2c2c2c", ramp); end
    endtask

    task automatic test_enable_drop();
        int bad;
        for (int pass = 0; pass < 2; pass++) begin
            tick(1'b1, 1'b1, 2'd0);
            for (int c = 0; c <= 10 * HT + 300; c++) tick(1'b1, 1'b0, 2'd0);
            vectors++;
            if (o_x !== 12'd300 || o_y !== 12'd10 || o_de !== 1'b1) begin
                miscompares++;
                $display("FAIL position_%0d: got x=%0d y=%0d de=%b expected x=300 y=10 de=1", pass, o_x, o_y, o_de);
            end
            if (pass == 1) begin
                @(negedge pixclk);
                reset = 1'b1;
                #1;
                vectors++;
                if (obs !== rst_o) begin
                    miscompares++;
                    $display("FAIL async_reset: got %h expected %h", obs, rst_o);
                end
            end
            bad = 0;
            for (int c = 0; c < 5; c++) begin
                tick(pass == 0 ? 1'b0 : 1'b1, pass == 1, 2'd0);
                if (obs !== rst_o || o_ctrl !== 2'b11) bad++;
            end
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL hold_%0d: got %0d bad cycles expected 0", pass, bad); end
            tick(1'b1, 1'b0, 2'd0);
            vectors++;
            if (o_x !== 12'd0 || o_y !== 12'd0 || o_frame_start !== 1'b1 || o_de !== 1'b1) begin
                miscompares++;
                $display("FAIL restart_%0d: got x=%0d y=%0d fs=%b de=%b expected 0 0 1 1",
                         pass, o_x, o_y, o_frame_start, o_de);
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        logic [1:0] pat = 2'd0;
        out_t first_o, first_e;
        first_o = '0;
        first_e = '0;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 63) == 0) pat = 2'($urandom_range(0, 3));
            tick($urandom_range(0, 499) != 0, $urandom_range(0, 999) == 0, pat);
            if (masked(obs) !== expv || o_ctrl !== {o_vsync, o_hsync}) begin
                if (bad == 0) begin first_o = obs; first_e = expv; end
                bad++;
            end
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL random_model: %0d bad cycles, first got %h expected %h", bad, first_o, first_e); end
    endtask

    initial begin
        rst_o = '0;
        rst_o.hs = 1'b1;
        rst_o.vs = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_bars();
        test_grid_ramp();
        test_enable_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
